cache_way_ctrl: RTL and testbench
=================================

Name: cache_way_ctrl

Overview:
Per-set tag and way-allocation controller for the 4-way set-associative cache. Accepts one lookup at a time and compares the stored tags of all ways. On a hit it drives the one-hot way select into the line-data way mux. On a miss it runs the refill handshake to memory, picks a victim by tree pseudo-LRU, and issues per-way write enables to the external data arrays.

Parameters:
WAYS, 4, associativity; power of two, >= 2
SETS, 16, number of sets; power of two
LINE_SIZE_BYTES, 4, bytes per line; power of two
ADDR_W, 32, request address width

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_req_valid  input  1  lookup request
o_req_ready  output  1  controller can accept a request
i_req_addr  input  ADDR_W  byte address of request
o_rsp_valid  output  1  one-cycle response pulse
o_rsp_hit  output  1  1 = hit, 0 = line was refilled
o_way_sel  output  WAYS  one-hot way select to the data mux
o_data_index  output  log2(SETS)  set index to the data arrays
o_data_we  output  WAYS  one-hot data-array write enable, refill cycle only
o_mem_req_valid  output  1  refill request
i_mem_req_ready  input  1  memory accepts refill request
o_mem_addr  output  ADDR_W  line-aligned refill address
i_mem_rsp_valid  input  1  refill data present; data arrays capture it

Behaviour:
- Clock and reset: single clock i_clk. i_rst_n is asynchronous assert, synchronous deassert by the system; active-low.
- Address split: OFF = log2(LINE_SIZE_BYTES), IDX = log2(SETS), TAG = ADDR_W - OFF - IDX. Index = addr[OFF+IDX-1:OFF]; tag = upper TAG bits.
- Storage:
  - tag[SETS][WAYS] and valid[SETS][WAYS] as flops.
  - plru[SETS][WAYS-1] as a heap-indexed tree: node 0 is the root; children of node n are 2n+1 and 2n+2.
  - Node bit 0 means the victim lies in the lower half, 1 the upper half.
- Reset: state=IDLE; every valid and plru bit cleared; all outputs 0 except o_req_ready=1 once in IDLE. Tags are not reset.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, register the address and go to LOOKUP.
- LOOKUP (1 cycle):
  - Compare the registered tag against every valid way at the index.
  - Hit: latch the one-hot match into o_way_sel, update plru, go to RESP.
  - Multiple matches (illegal): the lowest way wins.
  - Miss: victim = lowest-index invalid way; if all ways are valid, follow the plru tree. Go to MISS_REQ.
- MISS_REQ:
  - o_mem_req_valid=1 and o_mem_addr = {tag, index, OFF zeros}, both held stable until i_mem_req_ready.
  - On handshake, go to MISS_WAIT.
- MISS_WAIT:
  - On i_mem_rsp_valid, drive o_data_we = one-hot victim combinationally in that cycle.
  - In the same cycle: write the tag, set valid, update plru, set o_way_sel = victim, go to RESP.
  - i_mem_rsp_valid is ignored in every other state.
- RESP:
  - o_rsp_valid=1 for exactly one cycle; o_rsp_hit as determined; o_way_sel and o_data_index valid.
  - Next state is IDLE.
- Output hold: o_way_sel and o_data_index hold their values until the next LOOKUP.
- PLRU update: on access to way w, every node on w's path is set to point away from w.
- Latency: hit gives o_rsp_valid 2 cycles after the accept edge; a miss takes 3 cycles plus memory latency.
- No response back-pressure. o_req_ready=0 outside IDLE; requests presented then are not accepted.
- Reset mid-operation: immediate return to the reset state. Any in-flight refill is abandoned, and a late i_mem_rsp_valid is ignored.

Optional Feature:
- CACHE_WAY_CTRL_STATS_EN defined: adds o_hit_count and o_miss_count, 32-bit each, saturating at 0xFFFF_FFFF.
  - Hit count increments in LOOKUP on a hit.
  - Miss count increments in LOOKUP on a miss.
  - Both counters are cleared by reset.
- Undefined: these ports and counters are absent.

Decomposition:
- Package cache_pkg holds the FSM state enum and the OFF/IDX/TAG width functions.
- Sub-module plru_tree (parameter WAYS) is combinational. Input: tree bits plus an access way; outputs: victim one-hot and the updated bits.

Test Plan (WAYS=4, SETS=16, LINE_SIZE_BYTES=4, ADDR_W=32; index = addr[5:2]):
1. Cold miss, after reset: req 0x40 -> o_mem_addr=0x40; victim way0; on mem rsp o_data_we=0001; then o_rsp_valid=1, o_rsp_hit=0, o_way_sel=0001.
2. Hit: req 0x40 again -> o_rsp_valid 2 cycles after accept, o_rsp_hit=1, o_way_sel=0001, no o_mem_req_valid.
3. PLRU victim: fill set 0 with 0x40, 0x80, 0xC0, 0x100 (ways 0..3), hit 0x40, then req 0x140 -> o_data_we=0100 (way2).
4. Memory stall: i_mem_req_ready=0 for 5 cycles -> o_mem_req_valid and o_mem_addr held stable; o_req_ready=0; a concurrent i_req_valid is not accepted.
5. Reset mid-miss: drop i_rst_n in MISS_WAIT -> all outputs 0 immediately. After release, an i_mem_rsp_valid pulse produces no o_data_we, and req 0x40 misses again.
6. Stats (macro defined): sequence miss, hit, hit, miss -> o_hit_count=2, o_miss_count=2; counters clear on reset.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative cache.
// Optional statistics counters: CACHE_WAY_CTRL_STATS_EN.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_RESP
    } state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes,
                                 input int sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_way_ctrl_plru_tree.sv
// Combinational tree pseudo-LRU: victim lookup and access update.
// Heap-indexed nodes; bit 0 points to the lower half, 1 to the upper.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         i_bits,
    input  logic [$clog2(WAYS)-1:0] i_way,
    output logic [WAYS-1:0]         o_victim,
    output logic [WAYS-2:0]         o_bits
);

    localparam int WW = $clog2(WAYS);

    always_comb begin
        int node;
        node     = 0;
        o_victim = '0;
        for (int l = 0; l < WW; l++) begin
            node = 2 * node + 1 + int'(i_bits[node]);
        end
        o_victim[node - (WAYS - 1)] = 1'b1;
    end

    // Walk the accessed way's path, pointing each node at the other half.
    always_comb begin
        int node;
        node   = 0;
        o_bits = i_bits;
        for (int l = 0; l < WW; l++) begin
            o_bits[node] = ~i_way[WW-1-l];
            node = 2 * node + 1 + int'(i_way[WW-1-l]);
        end
    end

endmodule

// File: rtl/cache_way_ctrl.sv
// Per-set tag/valid/PLRU controller with refill handshake.
// Optional hit/miss counters: CACHE_WAY_CTRL_STATS_EN.
module cache_way_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS            = 4,
    parameter int SETS            = 16,
    parameter int LINE_SIZE_BYTES = 4,
    parameter int ADDR_W          = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDR_W-1:0]        i_req_addr,
    output logic                     o_rsp_valid,
    output logic                     o_rsp_hit,
    output logic [WAYS-1:0]          o_way_sel,
    output logic [idx_w(SETS)-1:0]   o_data_index,
    output logic [WAYS-1:0]          o_data_we,
    output logic                     o_mem_req_valid,
    input  logic                     i_mem_req_ready,
    output logic [ADDR_W-1:0]        o_mem_addr,
    input  logic                     i_mem_rsp_valid
`ifdef CACHE_WAY_CTRL_STATS_EN
    ,
    output logic [31:0]              o_hit_count,
    output logic [31:0]              o_miss_count
`endif
);

    localparam int OFF = off_w(LINE_SIZE_BYTES);
    localparam int IDX = idx_w(SETS);
    localparam int TAG = tag_w(ADDR_W, LINE_SIZE_BYTES, SETS);
    localparam int WW  = $clog2(WAYS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit_q, hit_d;
    logic [WAYS-1:0]   way_sel_q, way_sel_d;
    logic [IDX-1:0]    index_q, index_d;
    logic [WW-1:0]     vway_q, vway_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];
    logic [WAYS-2:0]   plru_d  [SETS];
    logic [TAG-1:0]    tag_q   [SETS][WAYS];
    logic [TAG-1:0]    tag_d   [SETS][WAYS];

    logic [IDX-1:0]    req_idx;
    logic [TAG-1:0]    req_tag;
    logic [WAYS-1:0]   match;
    logic [WW-1:0]     hit_way;
    logic [WW-1:0]     inv_way;
    logic [WW-1:0]     pv_way;
    logic [WW-1:0]     miss_way;
    logic [WW-1:0]     acc_way;
    logic [WAYS-1:0]   plru_victim;
    logic [WAYS-2:0]   plru_upd;
    logic [WAYS-1:0]   data_we;

    assign req_idx = addr_q[OFF+IDX-1:OFF];
    assign req_tag = addr_q[ADDR_W-1:OFF+IDX];

    always_comb begin
        match = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[req_idx][w] &&
                       (tag_q[req_idx][w] == req_tag);
        end
    end

    // Descending scans so the lowest qualifying way wins.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        pv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])              hit_way = WW'(w);
            if (!valid_q[req_idx][w])  inv_way = WW'(w);
            if (plru_victim[w])        pv_way  = WW'(w);
        end
    end

    assign miss_way = (&valid_q[req_idx]) ? pv_way : inv_way;
    assign acc_way  = (state_q == S_LOOKUP) ? hit_way : vway_q;

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .i_bits   (plru_q[req_idx]),
        .i_way    (acc_way),
        .o_victim (plru_victim),
        .o_bits   (plru_upd)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hit_d     = hit_q;
        way_sel_d = way_sel_q;
        index_d   = index_q;
        vway_d    = vway_q;
        valid_d   = valid_q;
        plru_d    = plru_q;
        tag_d     = tag_q;
        data_we   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    index_d = i_req_addr[OFF+IDX-1:OFF];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (|match) begin
                    hit_d           = 1'b1;
                    way_sel_d       = WAYS'(1) << hit_way;
                    plru_d[req_idx] = plru_upd;
                    state_d         = S_RESP;
                end else begin
                    hit_d   = 1'b0;
                    vway_d  = miss_way;
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (i_mem_req_ready) state_d = S_MISS_WAIT;
            end
            S_MISS_WAIT: begin
                if (i_mem_rsp_valid) begin
                    data_we                 = WAYS'(1) << vway_q;
                    tag_d[req_idx][vway_q]  = req_tag;
                    valid_d[req_idx][vway_q] = 1'b1;
                    plru_d[req_idx]         = plru_upd;
                    way_sel_d               = data_we;
                    state_d                 = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            hit_q     <= 1'b0;
            way_sel_q <= '0;
            index_q   <= '0;
            vway_q    <= '0;
            valid_q   <= '{default: '0};
            plru_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hit_q     <= hit_d;
            way_sel_q <= way_sel_d;
            index_q   <= index_d;
            vway_q    <= vway_d;
            valid_q   <= valid_d;
            plru_q    <= plru_d;
        end
    end

    // Tags are qualified by valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        tag_q <= tag_d;
    end

    assign o_req_ready     = (state_q == S_IDLE);
    assign o_rsp_valid     = (state_q == S_RESP);
    assign o_rsp_hit       = hit_q;
    assign o_way_sel       = way_sel_q;
    assign o_data_index    = index_q;
    assign o_data_we       = data_we;
    assign o_mem_req_valid = (state_q == S_MISS_REQ);
    assign o_mem_addr      = o_mem_req_valid ?
                             ((addr_q >> OFF) << OFF) : '0;

`ifdef CACHE_WAY_CTRL_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        lookup_hit, lookup_miss;

    assign lookup_hit  = (state_q == S_LOOKUP) && (|match);
    assign lookup_miss = (state_q == S_LOOKUP) && !(|match);

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_hit && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 32'd1;
        if (lookup_miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_hit_count  = hit_cnt_q;
    assign o_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed self-checking bench for cache_way_ctrl (WAYS=4, SETS=16).
module tb_cache_way_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic        o_rsp_valid;
    logic        o_rsp_hit;
    logic [3:0]  o_way_sel;
    logic [3:0]  o_data_index;
    logic [3:0]  o_data_we;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b1;
    logic [31:0] o_mem_addr;
    logic        i_mem_rsp_valid = 1'b0;
`ifdef CACHE_WAY_CTRL_STATS_EN
    logic [31:0] o_hit_count;
    logic [31:0] o_miss_count;
`endif

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 i_clk = ~i_clk;

    cache_way_ctrl #(
        .WAYS            (4),
        .SETS            (16),
        .LINE_SIZE_BYTES (4),
        .ADDR_W          (32)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_addr      (i_req_addr),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_hit       (o_rsp_hit),
        .o_way_sel       (o_way_sel),
        .o_data_index    (o_data_index),
        .o_data_we       (o_data_we),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid)
`ifdef CACHE_WAY_CTRL_STATS_EN
        ,
        .o_hit_count     (o_hit_count),
        .o_miss_count    (o_miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One request; memory accepts at once and answers the next cycle.
    task automatic do_req(input logic [31:0] a, input logic eh,
                          input logic [3:0] ew, input logic [3:0] ewe);
        int          n;
        logic        mem;
        logic [3:0]  we;
        logic [31:0] mad;
        n   = 0;
        mem = 1'b0;
        we  = '0;
        mad = '0;
        i_req_valid = 1'b1;
        i_req_addr  = a;
        tick();
        i_req_valid = 1'b0;
        while (!o_rsp_valid && n < 40) begin
            if (o_mem_req_valid) begin
                mem = 1'b1;
                mad = o_mem_addr;
                tick();
                i_mem_rsp_valid = 1'b1;
                #1;
                we = o_data_we;
                tick();
                i_mem_rsp_valid = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("rsp_hit", 32'(o_rsp_hit), 32'(eh));
        chk("way_sel", 32'(o_way_sel), 32'(ew));
        chk("data_index", 32'(o_data_index), 32'(a[5:2]));
        chk("data_we", 32'(we), 32'(ewe));
        chk("mem_used", 32'(mem), 32'(!eh));
        chk("latency", n, eh ? 1 : 2);
        if (!eh) chk("mem_addr", mad, a & 32'hFFFF_FFFC);
        tick();
        chk("rsp_pulse", 32'(o_rsp_valid), 32'd0);
        chk("ready_back", 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(o_rsp_hit), 32'd0);
        chk("rst_way_sel", 32'(o_way_sel), 32'd0);
        chk("rst_index", 32'(o_data_index), 32'd0);
        chk("rst_we", 32'(o_data_we), 32'd0);
        chk("rst_mem_valid", 32'(o_mem_req_valid), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // cold miss then hit in set 0
        do_req(32'h40, 1'b0, 4'b0001, 4'b0001);
        do_req(32'h40, 1'b1, 4'b0001, 4'b0000);

        // fill set 0, touch way0, plru then picks way2
        do_req(32'h80,  1'b0, 4'b0010, 4'b0010);
        do_req(32'hC0,  1'b0, 4'b0100, 4'b0100);
        do_req(32'h100, 1'b0, 4'b1000, 4'b1000);
        do_req(32'h40,  1'b1, 4'b0001, 4'b0000);
        do_req(32'h140, 1'b0, 4'b0100, 4'b0100);
        do_req(32'h140, 1'b1, 4'b0100, 4'b0000);
        do_req(32'h80,  1'b1, 4'b0010, 4'b0000);

        // memory stall with a competing request
        i_mem_req_ready = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h204;
        tick();
        i_req_addr  = 32'h40;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_mem_valid", 32'(o_mem_req_valid), 32'd1);
            chk("stall_mem_addr", o_mem_addr, 32'h204);
            chk("stall_ready", 32'(o_req_ready), 32'd0);
            tick();
        end
        i_req_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        chk("stall_mem_valid_end", 32'(o_mem_req_valid), 32'd1);
        tick();
        i_mem_rsp_valid = 1'b1;
        #1;
        chk("stall_we", 32'(o_data_we), 32'b0001);
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("stall_rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("stall_rsp_hit", 32'(o_rsp_hit), 32'd0);
        chk("stall_way_sel", 32'(o_way_sel), 32'b0001);
        chk("stall_index", 32'(o_data_index), 32'd1);
        tick();
        chk("stall_no_extra", 32'(o_rsp_valid), 32'd0);
        tick();
        chk("stall_no_extra2", 32'(o_rsp_valid), 32'd0);
        chk("stall_idle", 32'(o_req_ready), 32'd1);

        // reset while waiting for refill data
        i_req_valid = 1'b1;
        i_req_addr  = 32'h300;
        tick();
        i_req_valid = 1'b0;
        tick();
        chk("rm_mem_valid", 32'(o_mem_req_valid), 32'd1);
        tick();
        i_rst_n = 1'b0;
        i_mem_rsp_valid = 1'b1;
        #1;
        chk("rm_we", 32'(o_data_we), 32'd0);
        chk("rm_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rm_mem_valid0", 32'(o_mem_req_valid), 32'd0);
        chk("rm_mem_addr", o_mem_addr, 32'd0);
        chk("rm_way_sel", 32'(o_way_sel), 32'd0);
        chk("rm_index", 32'(o_data_index), 32'd0);
        chk("rm_hit", 32'(o_rsp_hit), 32'd0);
        tick();
        i_rst_n = 1'b1;
        #1;
        chk("rm_late_we", 32'(o_data_we), 32'd0);
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("rm_late_rsp", 32'(o_rsp_valid), 32'd0);
        chk("rm_ready", 32'(o_req_ready), 32'd1);
        do_req(32'h40, 1'b0, 4'b0001, 4'b0001);

        // miss, hit, hit, miss since the last reset
        do_req(32'h40, 1'b1, 4'b0001, 4'b0000);
        do_req(32'h40, 1'b1, 4'b0001, 4'b0000);
        do_req(32'h84, 1'b0, 4'b0001, 4'b0001);
`ifdef CACHE_WAY_CTRL_STATS_EN
        chk("hit_count", o_hit_count, 32'd2);
        chk("miss_count", o_miss_count, 32'd2);
        i_rst_n = 1'b0;
        #1;
        chk("hit_count_rst", o_hit_count, 32'd0);
        chk("miss_count_rst", o_miss_count, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
